seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU group.
- Sits beside the execute-stage ALU. Consumes the same 64-bit operand pair the ALU adder receives, and produces a 64-bit result for the writeback mux.
- The per-iteration add uses a ripple add built from the existing 1-bit full adder cell.
- One product takes XLEN+2 cycles. The pipeline stalls on busy_out.

Parameters:
- XLEN, 64, operand and result width. Iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start_in  input  1  request a multiply. Sampled only when state is IDLE or DONE.
- op_in  input  2  mul_op_t: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand1_in  input  XLEN  rs1 value. Captured with start_in.
- operand2_in  input  XLEN  rs2 value. Captured with start_in.
- busy_out  output  1  high in RUN and FIXUP.
- done_out  output  1  one-cycle pulse, result valid.
- result_out  output  XLEN  product slice. Held stable until the next accepted start.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (reset_n).
- Reset: when reset_n=0 at a clk edge:
  - state goes to IDLE; busy_out=0, done_out=0, result_out=0.
  - product, multiplier, count and negate registers clear.
  - Reset mid-RUN or mid-FIXUP aborts the operation with no done_out.
  - start_in is ignored while reset_n=0.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE/DONE with start_in=1 (accept):
  - Latch op into op_q.
  - mag1 = |operand1| if op is signed-op1 (MULH, MULHSU), else raw.
  - mag2 = |operand2| if op is MULH, else raw.
  - negate_q = sign1&signed1 XOR sign2&signed2.
  - Product register (2*XLEN+1 bits) high half = 0, low half = mag2. Multiplicand register = mag1. count = 0.
  - Go to RUN.
- DONE with start_in=0: go to IDLE.
- RUN, each cycle:
  - If product[0]=1, add the multiplicand to the high XLEN bits, giving an XLEN+1-bit sum that includes carry_out.
  - Shift the whole register right by 1.
  - count += 1. When count == XLEN-1 this cycle, go to FIXUP.
- FIXUP:
  - If negate_q, product = two's complement of the 2*XLEN product.
  - result_out = low XLEN bits for MUL, else high XLEN bits.
  - Go to DONE.
- DONE: done_out=1 for this single cycle only.
- Latency: start sampled in cycle S gives done_out in cycle S+XLEN+2 (66 for XLEN=64).
- start_in in RUN or FIXUP is ignored. It is not queued.
- Back-to-back: start_in in the DONE cycle is accepted. done_out still pulses in that cycle and RUN begins next cycle.
- MUL ignores sign: the low XLEN bits are identical for signed and unsigned.
- Magnitude of the most negative value (0x8000…0) is 0x8000… as unsigned. This is correct because the add path is XLEN+1 wide.
- Operand registers are isolated from inputs after accept. Changes on operand*_in during RUN have no effect.

Optional Feature:
- Macro: SEQ_MUL_ZERO_SKIP_EN.
- Defined: at accept, if mag1==0 or mag2==0, bypass RUN and go to FIXUP with the product forced to 0. done_out then appears in cycle S+2 with result_out=0.
- Undefined: every operation takes the full S+XLEN+2 cycles, regardless of operands.

Decomposition:
- Package mul_pkg holds:
  - localparam XLEN_DEFAULT=64.
  - typedef enum logic[1:0] mul_op_t {MUL, MULH, MULHSU, MULHU}.
  - typedef enum mul_state_t {IDLE, RUN, FIXUP, DONE}.
  - Function is_signed_op1(mul_op_t) and function is_signed_op2(mul_op_t).
- One sub-module, mul_add_shift: the combinational add-and-shift step.
  - Ports: current product, multiplicand, next product.
  - Internally a generate chain of XLEN FullAdder1b instances.
  - The FSM, registers and sign fixup stay in seq_multiplier.

Test Plan:
- MUL: 3 × 5, start at cycle 0 → done_out only at cycle 66, result_out=0x000…000F, busy_out high cycles 1–65.
- MULHU: 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → result_out=0xFFFF_FFFF_FFFF_FFFE.
- MULH and MULHSU:
  - MULH −1 × −1 → 0x0.
  - MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
  - MUL 0x8000_0000_0000_0000 × −1 → 0x8000_0000_0000_0000.
- Handshake:
  - start_in pulsed at cycles 10 and 40 during RUN → ignored, exactly one done_out.
  - New start in the DONE cycle → second done_out exactly 66 cycles later.
- Reset: reset_n=0 at cycle 30 of RUN → IDLE, all outputs 0, no done_out. A start after release completes normally.
- Zero operand: operand1=0 → with SEQ_MUL_ZERO_SKIP_EN, done_out at cycle 2 with result 0. Without it, done_out at cycle 66 with result 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential RV64M multiplier.
// Op encodings, FSM states and operand signedness helpers.
package mul_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mul_state_t;

  function automatic logic is_signed_op1(mul_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic is_signed_op2(mul_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/FullAdder1b.sv
// 1-bit full adder cell used by the multiplier ripple chain.
// Ports: a_i, b_i, c_i in; s_o sum, c_o carry out.
module FullAdder1b (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mul_add_shift.sv
// One radix-2 shift-add step of the sequential multiplier.
// Ports: prod_i current product, mcand_i multiplicand, prod_o next product.
module mul_add_shift #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN:0]  prod_i,
  input  logic [XLEN-1:0]  mcand_i,
  output logic [2*XLEN:0]  prod_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;
  logic [XLEN:0]   carry;
  logic            unused_msb;

  // The top bit is always clear before a step; only kept for width.
  assign unused_msb = prod_i[2*XLEN];

  assign addend   = prod_i[0] ? mcand_i : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < XLEN; i++) begin : g_fa
    FullAdder1b u_fa (
      .a_i (prod_i[XLEN+i]),
      .b_i (addend[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // Carry-out lands in the high half, so the shift keeps XLEN+1 bits.
  assign prod_o = {1'b0, carry[XLEN], sum, prod_i[XLEN-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Ports: clk, reset_n (sync, active-low), start_in, op_in,
//   operand1_in, operand2_in; busy_out, done_out, result_out.
// Optional SEQ_MUL_ZERO_SKIP_EN: zero operand skips RUN entirely.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] operand1_in,
  input  logic [XLEN-1:0] operand2_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN);

  mul_state_t      state_q, state_d;
  mul_op_t         op_q, op_d;
  logic            neg_q, neg_d;
  logic [2*XLEN:0] prod_q, prod_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;

  mul_op_t           op_new;
  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN:0]   prod_step;
  logic [2*XLEN-1:0] prod_fix;

  assign op_new = mul_op_t'(op_in);
  assign sgn1   = operand1_in[XLEN-1] & is_signed_op1(op_new);
  assign sgn2   = operand2_in[XLEN-1] & is_signed_op2(op_new);
  // Negating the most negative value yields itself, read as unsigned.
  assign mag1   = sgn1 ? -operand1_in : operand1_in;
  assign mag2   = sgn2 ? -operand2_in : operand2_in;

  assign prod_fix = neg_q ? -prod_q[2*XLEN-1:0]
                          : prod_q[2*XLEN-1:0];

  mul_add_shift #(.XLEN(XLEN)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (prod_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          op_d    = op_new;
          neg_d   = sgn1 ^ sgn2;
          mcand_d = mag1;
          prod_d  = {{(XLEN+1){1'b0}}, mag2};
          cnt_d   = '0;
          state_d = RUN;
`ifdef SEQ_MUL_ZERO_SKIP_EN
          if (mag1 == '0 || mag2 == '0) begin
            prod_d  = '0;
            state_d = FIXUP;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIXUP;
      end
      FIXUP: begin
        prod_d  = {1'b0, prod_fix};
        res_d   = (op_q == MUL) ? prod_fix[XLEN-1:0]
                                : prod_fix[2*XLEN-1:XLEN];
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MUL;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy_out   = (state_q == RUN) || (state_q == FIXUP);
  assign done_out   = (state_q == DONE);
  assign result_out = res_q;

endmodule
